if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the MIPS pipeline.
- Owns the program counter and drives the word address into the combinational instruction memory.
- Captures the returned instruction into the IF/ID pipeline register.
- Honours load-use stalls from the hazard unit and branch redirects from the branch-resolution stage, squashing the wrong-path instruction as a bubble.

Parameters:
RESET_PC, 32'h0000_0000, word address loaded into the PC at reset
NOP_INSTR, 32'h8000_0000, team bubble encoding inserted into IF/ID on reset and on flush
CNT_W, 32, width of the fetch performance counter

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard unit request: hold PC and IF/ID
branch_taken  input  1  redirect request from the branch-resolution stage
branch_target  input  32  redirect word address
imem_addr  output  32  word address to instruction memory (memory is indexed directly by this value)
imem_data  input  32  instruction returned combinationally for imem_addr
if_id_instr  output  32  registered instruction to decode
if_id_npc  output  32  registered PC+1 of that instruction
if_id_valid  output  1  1 = if_id_instr is a real fetched instruction, 0 = bubble
fetch_count  output  CNT_W  number of instructions delivered valid into IF/ID

Behaviour:
- Reset (rst_n low, asynchronous, takes effect without a clock edge):
  - pc = RESET_PC
  - if_id_instr = NOP_INSTR, if_id_npc = 0, if_id_valid = 0
  - fetch_count = 0
- imem_addr = pc, combinational. Memory read is combinational, so fetch latency is one cycle from PC to IF/ID.
- The PC is a word address. Sequential increment is +1, not +4. Arithmetic is modulo 2^32: pc 32'hFFFF_FFFF advances to 0.
- Per rising edge, priority is reset > branch_taken > stall > normal.
  - Normal (no stall, no branch):
    - pc <= pc+1
    - if_id_instr <= imem_data, if_id_npc <= pc+1, if_id_valid <= 1
    - fetch_count <= fetch_count+1
  - stall=1, branch_taken=0: pc, IF/ID and fetch_count all hold.
  - branch_taken=1, regardless of stall:
    - pc <= branch_target
    - if_id_instr <= NOP_INSTR, if_id_npc <= 0, if_id_valid <= 0
    - fetch_count holds
    - The instruction on imem_data this cycle is discarded.
- Redirect beats stall. A stalled wrong-path instruction must still be squashed. The hazard unit de-asserts stall once the bubble is seen.
- Back-to-back branch_taken on consecutive cycles: each redirect wins. The PC follows the latest target and IF/ID stays a bubble.
- branch_target equal to the current pc: legal. Behaves as refetch with a one-cycle bubble.
- fetch_count wraps modulo 2^CNT_W without saturation.
- Release of rst_n: the first fetch is captured on the first rising edge with rst_n high, provided stall=0.
- No handshake with memory: imem_data is assumed valid in the same cycle as imem_addr. X on imem_data is passed through only when the captured value is valid.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INSTR (32'h8000_0000)
  - RESET_PC default
  - WORD_W = 32
  - the opcode field slice constants used by decode
- Sub-module pc_reg: PC register with async active-low reset, load-enable, and next-PC mux (increment / target / hold).
- IF/ID register and fetch counter live in if_stage.

Test Plan:
1. Reset then free-run with memory word i = 32'h1000_0000+i. Hold rst_n low, then release; stall=0, branch_taken=0 for 4 edges. Required:
   - imem_addr = 0,1,2,3,4
   - if_id_instr = 32'h1000_0000..32'h1000_0003 with if_id_npc = 1..4
   - if_id_valid = 1 from the first edge
   - fetch_count = 4
2. Stall: after reaching pc=3, assert stall for 2 edges. Required:
   - pc stays 3
   - if_id_instr stays 32'h1000_0002
   - fetch_count unchanged
   - on release, the next edge captures 32'h1000_0003
3. Branch: at pc=5, pulse branch_taken with branch_target=20. Required:
   - next cycle imem_addr = 20, if_id_instr = 32'h8000_0000, if_id_valid = 0
   - the following edge captures 32'h1000_0014 with npc = 21
4. Branch with stall: stall=1 and branch_taken=1 together, target 40. Required:
   - pc = 40
   - IF/ID becomes the bubble
   - fetch_count unchanged
5. Wrap: force the PC via branch_target=32'hFFFF_FFFF, then run 2 edges. Required:
   - imem_addr sequence FFFF_FFFF, 0, 1
   - if_id_npc = 0 for the first captured word
6. Mid-run reset: assert rst_n low asynchronously between edges with pc=7 and valid=1. Required:
   - outputs go immediately to pc = 0, if_id_instr = 32'h8000_0000, valid = 0, fetch_count = 0
   - no clock edge is needed

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types.
package mips_pkg;

  localparam int WORD_W = 32;

  // Bubble encoding placed in pipeline registers on reset and flush.
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h8000_0000;

  // Default PC (word address) after reset.
  localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

  // Instruction field slices used by decode.
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  // Next-PC source; holding is done through the load enable.
  typedef enum logic {
    NPC_INC = 1'b0,
    NPC_TGT = 1'b1
  } npc_sel_e;

  // Opcode field of an instruction word.
  function automatic logic [OP_MSB-OP_LSB:0] opcode(input logic [WORD_W-1:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: word address, +1 increment, redirect target, hold via enable.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  npc_sel_e          sel,
  input  logic [WORD_W-1:0] target,
  output logic [WORD_W-1:0] pc
);

  logic [WORD_W-1:0] pc_next;

  // Next-PC mux; increment wraps modulo 2^32.
  always_comb begin
    pc_next = pc + 32'd1;
    if (sel == NPC_TGT) pc_next = target;
  end

  // PC register, loads only when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  pc <= RESET_PC;
    else if (en) pc <= pc_next;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, captures imem data into IF/ID,
// holds on stall, squashes the wrong-path fetch on redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_npc,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] fetch_count
);
  import mips_pkg::*;

  logic [WORD_W-1:0] pc;
  logic              pc_en;
  npc_sel_e          pc_sel;

  // Redirect beats stall, so a stalled wrong-path fetch still gets squashed.
  always_comb begin
    pc_en  = branch_taken | ~stall;
    pc_sel = branch_taken ? NPC_TGT : NPC_INC;
  end

  pc_reg #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (pc_en),
    .sel    (pc_sel),
    .target (branch_target),
    .pc     (pc)
  );

  // Memory is combinational and word-indexed, so the PC drives it directly.
  assign imem_addr = pc;

  // IF/ID register and delivered-fetch counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr <= NOP_INSTR;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
      fetch_count <= '0;
    end else if (branch_taken) begin
      if_id_instr <= NOP_INSTR;
      if_id_npc   <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_instr <= imem_data;
      if_id_npc   <= pc + 32'd1;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected post-edge state,
// a monitor pops and compares one entry after every rising edge.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h8000_0000;
  localparam logic [31:0] MEM_BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic [31:0] fetch_count;

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_id_instr   (if_id_instr),
    .if_id_npc     (if_id_npc),
    .if_id_valid   (if_id_valid),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: word i holds MEM_BASE + i.
  assign imem_data = MEM_BASE + imem_addr;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference state at the level of the architecture.
  exp_t m;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic model_reset();
    m.pc = 32'h0; m.instr = NOP; m.npc = 32'h0; m.valid = 1'b0; m.cnt = 32'h0;
  endtask

  // Apply one cycle of stimulus and predict the state after the next edge.
  task automatic step(input logic s, input logic b, input logic [31:0] t);
    @(negedge clk);
    rst_n = 1'b1; stall = s; branch_taken = b; branch_target = t;
    if (b) begin
      m.pc = t; m.instr = NOP; m.npc = 32'h0; m.valid = 1'b0;
    end else if (!s) begin
      m.instr = MEM_BASE + m.pc;
      m.npc   = m.pc + 32'd1;
      m.valid = 1'b1;
      m.cnt   = m.cnt + 32'd1;
      m.pc    = m.pc + 32'd1;
    end
    exp_q.push_back(m);
  endtask

  // Asynchronous reset between edges; outputs must change without a clock.
  task automatic async_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; #1;
    model_reset();
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr", if_id_instr, NOP);
    chk("rst_npc", if_id_npc, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst_count", fetch_count, 32'h0);
  endtask

  // Monitor: one expected entry per edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("imem_addr", imem_addr, e.pc);
      chk("if_id_instr", if_id_instr, e.instr);
      chk("if_id_npc", if_id_npc, e.npc);
      chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, e.valid});
      chk("fetch_count", fetch_count, e.cnt);
    end
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    chk("por_imem_addr", imem_addr, 32'h0);
    chk("por_instr", if_id_instr, NOP);
    chk("por_valid", {31'h0, if_id_valid}, 32'h0);
    chk("por_count", fetch_count, 32'h0);

    // Free run from reset.
    repeat (4) step(1'b0, 1'b0, '0);
    // Stall two edges, then release.
    repeat (2) step(1'b1, 1'b0, '0);
    repeat (2) step(1'b0, 1'b0, '0);
    // Plain redirect.
    step(1'b0, 1'b1, 32'd20);
    repeat (2) step(1'b0, 1'b0, '0);
    // Redirect while stalled.
    step(1'b1, 1'b1, 32'd40);
    step(1'b0, 1'b0, '0);
    // Back-to-back redirects, then refetch of the current pc.
    step(1'b0, 1'b1, 32'd100);
    step(1'b0, 1'b1, 32'd200);
    step(1'b0, 1'b1, 32'd200);
    step(1'b0, 1'b0, '0);
    // PC wrap.
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    repeat (2) step(1'b0, 1'b0, '0);

    // Mid-run reset with live state, then resume.
    async_reset();
    repeat (7) step(1'b0, 1'b0, '0);
    async_reset();
    step(1'b0, 1'b0, '0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic s, b;
      logic [31:0] t;
      s = ($urandom_range(3) == 0);
      b = ($urandom_range(7) == 0);
      case ($urandom_range(3))
        0: t = m.pc;
        1: t = 32'hFFFF_FFFF - $urandom_range(2);
        default: t = $urandom_range(1000);
      endcase
      step(s, b, t);
      if (i == 250) async_reset();
    end

    // Drain the scoreboard with a bounded wait.
    begin
      int budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      n_vec++;
      if (exp_q.size() > 0) begin
        n_err++;
        $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
